// File: rtl/fwd_pkg.sv
// Shared encodings, FSM state type and the operand-slice helper used by
// the forwarding/hazard controller.
package fwd_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } fsm_state_e;

  // Widest packed source vector the slice helper accepts.
  localparam int SLICE_MAX_W = 256;

  // Extract field idx of width w from a packed vector.
  function automatic logic [31:0] src_slice(input logic [SLICE_MAX_W-1:0] vec,
                                            input int idx,
                                            input int w);
    logic [SLICE_MAX_W-1:0] sh;
    logic [31:0]            mask;
    sh   = vec >> (idx * w);
    mask = (32'd1 << w) - 32'd1;
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Single-source forwarding comparator: picks MEM, then WB, then regfile.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic              rs_used,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs_used && mem_regwrite && (mem_rd != '0) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (rs_used && wb_regwrite && (wb_rd != '0) && (wb_rd == rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard controller: per-source EX forwarding, load-use stall,
// dmem wait freeze with timeout, branch flush and a stall performance counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [NUM_SRC*ADDR_W-1:0] ex_rs,
  input  logic [NUM_SRC-1:0]        ex_rs_used,
  input  logic [ADDR_W-1:0]         ex_rd,
  input  logic                      ex_memread,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic                      mem_regwrite,
  input  logic                      mem_memread,
  input  logic                      dmem_ready,
  input  logic [ADDR_W-1:0]         wb_rd,
  input  logic                      wb_regwrite,
  input  logic                      flush_req,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      id_ex_en,
  output logic                      ex_mem_en,
  output logic                      mem_wb_en,
  output logic                      if_id_flush,
  output logic                      id_ex_bubble,
  output logic                      mem_timeout,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  fsm_state_e        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              lu;
  logic              stall;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [ADDR_W-1:0] ex_src;
    assign ex_src = ADDR_W'(src_slice(SLICE_MAX_W'(ex_rs), g, ADDR_W));

    fwd_match #(.ADDR_W(ADDR_W)) u_match (
      .rs           (ex_src),
      .rs_used      (ex_rs_used[g]),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_sel[2*g +: 2])
    );
  end

  always_comb begin
    logic any_match;
    any_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] &&
          (ADDR_W'(src_slice(SLICE_MAX_W'(id_rs), i, ADDR_W)) == ex_rd))
        any_match = 1'b1;
    end
    lu = ex_memread && (ex_rd != '0) && any_match;
  end

  // The cycle dmem_ready rises is not frozen, so the load retires normally.
  assign freeze = ((state == RUN) && mem_memread && !dmem_ready) ||
                  ((state == MEM_WAIT) && !dmem_ready);

  // A load-use overridden by a flush squashes the consumer; no stall happens.
  assign stall = freeze || (lu && !flush_req);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_memread && !dmem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (flush_req) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(MAX_WAIT - 1))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if ((state == MEM_WAIT) && !dmem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1)))
        mem_timeout <= 1'b1;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard controller for the 5-stage RISC-V pipeline.
- Generalises operand forwarding to NUM_SRC EX-stage sources with independent per-source selects.
- Adds load-use stall detection, a multi-cycle data-memory wait FSM that freezes the pipeline, and branch-flush sequencing.
- Sits beside the datapath; drives the pipeline-register enables/bubbles and the EX operand muxes.

Parameters:
- ADDR_W, 5, register-address width.
- NUM_SRC, 2, source operands per instruction (3 for future fused ops).
- MAX_WAIT, 64, dmem wait cycles before mem_timeout is flagged.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  NUM_SRC*ADDR_W  ID-stage source addresses; source i at bits [i*ADDR_W +: ADDR_W].
- id_rs_used  in  NUM_SRC  ID source i actually read.
- ex_rs  in  NUM_SRC*ADDR_W  EX-stage source addresses, same packing.
- ex_rs_used  in  NUM_SRC  EX source i actually read.
- ex_rd  in  ADDR_W  EX destination.
- ex_memread  in  1  EX instruction is a load.
- mem_rd  in  ADDR_W  MEM destination.
- mem_regwrite  in  1  MEM writes rd.
- mem_memread  in  1  MEM instruction is a load.
- dmem_ready  in  1  data memory returns load data this cycle.
- wb_rd  in  ADDR_W  WB destination.
- wb_regwrite  in  1  WB writes rd.
- flush_req  in  1  taken branch/jump resolved in EX.
- fwd_sel  out  2*NUM_SRC  per-source select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 unused.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline-register enables.
- if_id_flush, id_ex_bubble  out  1 each  zero the register's control fields.
- mem_timeout  out  1  sticky wait-timeout error.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Forwarding (combinational), per source i independently:
  - 01 if ex_rs_used[i] && mem_regwrite && mem_rd!=0 && mem_rd==ex_rs[i].
  - Else 10 if the same conditions hold against wb_regwrite/wb_rd.
  - Else 00.
  - MEM has priority over WB.
  - rd==0 never forwards.
- Load-use: lu = ex_memread && ex_rd!=0 && any i with id_rs_used[i] && id_rs[i]==ex_rd.
- FSM states RUN, MEM_WAIT; reset state RUN.
  - RUN -> MEM_WAIT when mem_memread && !dmem_ready.
  - MEM_WAIT -> RUN on dmem_ready.
  - freeze = (state==RUN && mem_memread && !dmem_ready) || (state==MEM_WAIT && !dmem_ready).
  - The cycle dmem_ready rises is a normal advancing cycle.
- Output priority: freeze > flush_req > lu > normal.
  - freeze: all five enables 0, no flush/bubble; WB holds, so its forward value stays valid.
  - flush_req (no freeze): all enables 1, if_id_flush=1, id_ex_bubble=1; lu ignored because the dependent instruction is squashed.
  - lu: pc_en=0, if_id_en=0, id_ex_bubble=1, others 1; exactly one bubble per load.
  - normal: all enables 1, flush/bubble 0.
  - flush_req during freeze is ignored; the branch stays in EX and re-asserts on release.
- wait_cnt:
  - Clears in RUN and increments each MEM_WAIT cycle.
  - At wait_cnt==MAX_WAIT-1 with !dmem_ready, mem_timeout sets and stays set until reset.
  - The freeze continues after timeout.
- stall_cnt increments on any freeze or lu cycle and saturates at all-ones.
- Reset (wins over all, any state): state RUN, wait_cnt 0, stall_cnt 0, mem_timeout 0.
  - Combinational outputs follow RUN rules from the next cycle.
  - During the reset cycle itself enables are don't-care; the top level also resets the pipeline registers.

Decomposition:
- Package fwd_pkg holds:
  - FWD_RF/FWD_MEM/FWD_WB encodings.
  - The state enum {RUN, MEM_WAIT}.
  - Helper function src_slice.
- Sub-module fwd_match: a single-source comparator producing the 2-bit select, instantiated NUM_SRC times in a generate loop.

Test Plan:
- ex_rs={x5,x6}, mem_rd=x5 regwrite, wb_rd=x6 regwrite -> fwd_sel={src1:10, src0:01}.
- mem_rd=wb_rd=x7, both regwrite, ex_rs0=x7 -> src0=01. ex_rs0=x0, mem_rd=x0 regwrite -> 00.
- ex_memread, ex_rd=x9, id_rs1=x9 used -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt +1. Same case with flush_req=1 -> no stall, if_id_flush=1, id_ex_bubble=1.
- mem_memread, dmem_ready low 3 cycles -> 3 cycles with all enables 0, state MEM_WAIT; the 4th cycle advances; stall_cnt=3.
- MAX_WAIT=4, dmem_ready held low -> mem_timeout rises after the 4th wait cycle and stays high; reset clears it and returns to RUN.
- stall_cnt preloaded near all-ones via a long freeze with CNT_W=4 -> holds at 15.
